// File: rtl/tcm_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port TCM SRAM
// with 1-cycle read latency and per-owner response backpressure.
module tcm_arbiter #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned MW     = 4,
   parameter int unsigned RAM_AW = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_cmd_valid,
   output logic              m0_cmd_ready,
   input  logic              m0_cmd_read,
   input  logic [AW-1:0]     m0_cmd_addr,
   input  logic [DW-1:0]     m0_cmd_wdata,
   input  logic [MW-1:0]     m0_cmd_wmask,
   output logic              m0_rsp_valid,
   input  logic              m0_rsp_ready,
   output logic [DW-1:0]     m0_rsp_rdata,
   input  logic              m1_cmd_valid,
   output logic              m1_cmd_ready,
   input  logic              m1_cmd_read,
   input  logic [AW-1:0]     m1_cmd_addr,
   input  logic [DW-1:0]     m1_cmd_wdata,
   input  logic [MW-1:0]     m1_cmd_wmask,
   output logic              m1_rsp_valid,
   input  logic              m1_rsp_ready,
   output logic [DW-1:0]     m1_rsp_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_din,
   output logic              ram_we,
   output logic [MW-1:0]     ram_wem,
   input  logic [DW-1:0]     ram_dout
);

   logic              pend;
   logic              own;
   logic              pend_rd;
   logic              hold_v;
   logic              last;
   logic [DW-1:0]     hold;
   logic [RAM_AW-1:0] addr_q;

   logic              stall;
   logic              rsp_fire;
   logic              gnt0;
   logic              gnt1;
   logic              fire;
   logic              sel;
   logic              sel_read;
   logic [DW-1:0]     rdata;

   // Byte-offset bits and the bits above the SRAM depth are dropped on purpose.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_cmd_addr[AW-1:RAM_AW+2], m0_cmd_addr[1:0],
                               m1_cmd_addr[AW-1:RAM_AW+2], m1_cmd_addr[1:0]};

   // Grant, stall and SRAM drive; last == 1 means m1 was granted most recently.
   always_comb begin
      rsp_fire     = pend & (own ? m1_rsp_ready : m0_rsp_ready);
      stall        = pend & ~rsp_fire;
      gnt0         = m0_cmd_valid & (~m1_cmd_valid | last);
      gnt1         = m1_cmd_valid & (~m0_cmd_valid | ~last);
      m0_cmd_ready = gnt0 & ~stall & ~rst;
      m1_cmd_ready = gnt1 & ~stall & ~rst;
      fire         = m0_cmd_ready | m1_cmd_ready;
      sel          = m1_cmd_ready;
      sel_read     = sel ? m1_cmd_read : m0_cmd_read;

      ram_addr = addr_q;
      ram_din  = '0;
      ram_we   = 1'b0;
      ram_wem  = '0;
      if (fire) begin
         ram_addr = sel ? m1_cmd_addr[RAM_AW+1:2] : m0_cmd_addr[RAM_AW+1:2];
         ram_din  = sel ? m1_cmd_wdata : m0_cmd_wdata;
         ram_we   = ~sel_read;
         ram_wem  = sel_read ? MW'(0) : (sel ? m1_cmd_wmask : m0_cmd_wmask);
      end
   end

   // Response steering: live SRAM data in the first response cycle, held data after.
   always_comb begin
      rdata        = pend_rd ? (hold_v ? hold : ram_dout) : '0;
      m0_rsp_valid = pend & ~own & ~rst;
      m1_rsp_valid = pend & own & ~rst;
      m0_rsp_rdata = m0_rsp_valid ? rdata : '0;
      m1_rsp_rdata = m1_rsp_valid ? rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= 1'b0;
         own     <= 1'b0;
         pend_rd <= 1'b0;
         hold    <= '0;
         hold_v  <= 1'b0;
         last    <= 1'b1;
         addr_q  <= '0;
      end else if (fire) begin
         pend    <= 1'b1;
         own     <= sel;
         pend_rd <= sel_read;
         hold_v  <= 1'b0;
         last    <= sel;
         addr_q  <= ram_addr;
      end else begin
         if (rsp_fire) pend <= 1'b0;
         if (pend && !hold_v) begin
            hold   <= ram_dout;
            hold_v <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Directed bench for tcm_arbiter with a behavioural 1-cycle-latency SRAM model.
module tb_tcm_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
   logic [31:0] m0_cmd_addr, m0_cmd_wdata;
   logic [3:0]  m0_cmd_wmask;
   logic        m0_rsp_valid, m0_rsp_ready;
   logic [31:0] m0_rsp_rdata;
   logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
   logic [31:0] m1_cmd_addr, m1_cmd_wdata;
   logic [3:0]  m1_cmd_wmask;
   logic        m1_rsp_valid, m1_rsp_ready;
   logic [31:0] m1_rsp_rdata;
   logic [8:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [3:0]  ram_wem;
   logic [31:0] ram_dout;

   logic [31:0] mem [512];
   logic        loaded = 1'b0;

   int checks = 0;
   int errors = 0;
   int g0_cnt = 0;
   int g1_cnt = 0;

   always #5 clk = ~clk;

   tcm_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
      .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
      .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_wem(ram_wem),
      .ram_dout(ram_dout)
   );

   // SRAM model: preload mem[i] = C0DE_00ii, byte-masked write, registered read.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 512; i++) mem[i] <= {16'hC0DE, 16'(i)};
         loaded <= 1'b1;
      end else if (ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
      m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a; m0_cmd_wdata = d; m0_cmd_wmask = m;
   endtask

   task automatic drive1(input logic v, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
      m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a; m1_cmd_wdata = d; m1_cmd_wmask = m;
   endtask

   initial begin
      rst = 1'b1;
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      drive0(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF);
      drive1(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      tick();
      tick();
      #1;
      check("rst_m0_ready", 32'(m0_cmd_ready), 32'd0);
      check("rst_m1_ready", 32'(m1_cmd_ready), 32'd0);
      check("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_wem", 32'(ram_wem), 32'd0);

      // Tie after reset: m0 first, then m1
      rst = 1'b0;
      drive0(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("tie_m0_ready", 32'(m0_cmd_ready), 32'd1);
      check("tie_m1_ready", 32'(m1_cmd_ready), 32'd0);
      tick();
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("tie_m1_ready2", 32'(m1_cmd_ready), 32'd1);
      check("tie_m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
      check("tie_m0_rdata", m0_rsp_rdata, 32'hC0DE_0000);
      tick();
      drive1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("tie_m1_rsp_valid", 32'(m1_rsp_valid), 32'd1);
      check("tie_m1_rdata", m1_rsp_rdata, 32'hC0DE_0001);
      check("tie_m0_rdata_idle", m0_rsp_rdata, 32'd0);
      tick();

      // Full-rate writes then read-back
      drive0(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
      #1;
      check("wr1_ready", 32'(m0_cmd_ready), 32'd1);
      check("wr1_we", 32'(ram_we), 32'd1);
      check("wr1_addr", 32'(ram_addr), 32'd4);
      check("wr1_wem", 32'(ram_wem), 32'hF);
      tick();
      drive0(1'b1, 1'b0, 32'h10, 32'h0000_0055, 4'h1);
      #1;
      check("wr2_ready", 32'(m0_cmd_ready), 32'd1);
      check("wr1_rsp_rdata", m0_rsp_rdata, 32'd0);
      check("wr2_wem", 32'(ram_wem), 32'h1);
      tick();
      drive0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
      #1;
      check("rd_ready", 32'(m0_cmd_ready), 32'd1);
      check("rd_we", 32'(ram_we), 32'd0);
      check("wr2_rsp_rdata", m0_rsp_rdata, 32'd0);
      tick();
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("rd_rsp_valid", 32'(m0_rsp_valid), 32'd1);
      check("rd_rsp_rdata", m0_rsp_rdata, 32'hDEAD_BE55);
      check("idle_we", 32'(ram_we), 32'd0);
      check("idle_addr_hold", 32'(ram_addr), 32'd4);
      tick();

      // Backpressure on m0 while m1 waits
      drive0(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
      m0_rsp_ready = 1'b0;
      #1;
      check("bp_m0_ready", 32'(m0_cmd_ready), 32'd1);
      tick();
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      drive1(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_m1_ready_stalled", 32'(m1_cmd_ready), 32'd0);
         check("bp_m0_rdata_stable", m0_rsp_rdata, 32'hC0DE_0002);
         check("bp_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
         tick();
      end
      m0_rsp_ready = 1'b1;
      #1;
      check("bp_release_m1_ready", 32'(m1_cmd_ready), 32'd1);
      check("bp_release_m0_rdata", m0_rsp_rdata, 32'hC0DE_0002);
      tick();
      drive1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("bp_m1_rdata", m1_rsp_rdata, 32'hC0DE_0001);
      check("bp_m0_rsp_valid_off", 32'(m0_rsp_valid), 32'd0);
      tick();

      // Fairness: both valid for 8 cycles, m1 was granted last
      drive0(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      drive1(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fair_m0_ready", 32'(m0_cmd_ready), 32'((i % 2) == 0));
         check("fair_m1_ready", 32'(m1_cmd_ready), 32'((i % 2) == 1));
         if (i > 0)
            check("fair_rsp_rdata", (i % 2 == 1) ? m0_rsp_rdata : m1_rsp_rdata,
                  (i % 2 == 1) ? 32'hC0DE_0000 : 32'hC0DE_0001);
         if (m0_cmd_ready) g0_cnt++;
         if (m1_cmd_ready) g1_cnt++;
         tick();
      end
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      drive1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      check("fair_m0_count", 32'(g0_cnt), 32'd4);
      check("fair_m1_count", 32'(g1_cnt), 32'd4);
      tick();

      // Address wrap and ignored byte offset
      drive0(1'b1, 1'b1, 32'h800, 32'h0, 4'h0);
      #1;
      check("wrap_addr", 32'(ram_addr), 32'd0);
      tick();
      drive0(1'b1, 1'b1, 32'h3, 32'h0, 4'h0);
      #1;
      check("wrap_rdata", m0_rsp_rdata, 32'hC0DE_0000);
      check("offset_addr", 32'(ram_addr), 32'd0);
      tick();
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("offset_rdata", m0_rsp_rdata, 32'hC0DE_0000);
      tick();

      // Reset while m1's response is stalled
      drive1(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      m1_rsp_ready = 1'b0;
      tick();
      drive1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      #1;
      check("mid_m1_rsp_valid", 32'(m1_rsp_valid), 32'd1);
      rst = 1'b1;
      drive0(1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'hF);
      #1;
      check("mid_rst_we", 32'(ram_we), 32'd0);
      tick();
      rst = 1'b0;
      drive0(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      drive1(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      #1;
      check("post_rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
      check("post_rst_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
      check("post_rst_m0_ready", 32'(m0_cmd_ready), 32'd1);
      check("post_rst_m1_ready", 32'(m1_cmd_ready), 32'd0);
      tick();
      drive0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      drive1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      m1_rsp_ready = 1'b1;
      #1;
      check("post_rst_m0_rdata", m0_rsp_rdata, 32'hC0DE_0000);
      check("no_write_in_rst", mem[8], 32'hC0DE_0008);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
